// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit
// Purpose  : Writeback/commit stage. Merges in-order pipeline results (with
//            load alignment) and FIFO-buffered long-unit results into one
//            registered register-file write per cycle, and keeps the busy
//            scoreboard. Optional macro WB_BLOCK_CNT_EN adds a saturating
//            drain-blocked cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit #(
    parameter int LU_FIFO_DEPTH = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_valid,
    input  logic [4:0]       pipe_rd,
    input  logic             pipe_is_load,
    input  logic [2:0]       pipe_ld_type,
    input  logic [1:0]       pipe_addr_lo,
    input  logic [31:0]      pipe_data,
    input  logic             lu_issue,
    input  logic [4:0]       lu_issue_rd,
    input  logic             lu_done_valid,
    input  logic [4:0]       lu_done_rd,
    input  logic [31:0]      lu_done_data,
    output logic             lu_done_ready,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [31:0]      rf_wd,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int             AW     = $clog2(LU_FIFO_DEPTH);
    localparam int             CW     = AW + 1;
    localparam logic [CW-1:0]  C_FULL = CW'(LU_FIFO_DEPTH);

    logic [4:0]    fifo_rd_q   [LU_FIFO_DEPTH];
    logic [31:0]   fifo_data_q [LU_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_wa_q, rf_wa_d;
    logic [31:0]   rf_wd_q, rf_wd_d;
    logic [31:0]   busy_q, busy_d;

    logic          w_full, w_empty, w_push, w_pop, w_pipe_win;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_pipe_wd;

    assign w_full        = (cnt_q == C_FULL);
    assign w_empty       = (cnt_q == '0);
    assign lu_done_ready = !w_full;
    assign w_pipe_win    = pipe_valid && (pipe_rd != 5'd0);
    // Results for x0 are accepted but never stored.
    assign w_push        = lu_done_valid && !w_full && (lu_done_rd != 5'd0);
    assign w_pop         = !w_pipe_win && !w_empty;

    always_comb begin
        w_byte = pipe_data[7:0];
        case (pipe_addr_lo)
            2'd1:    w_byte = pipe_data[15:8];
            2'd2:    w_byte = pipe_data[23:16];
            2'd3:    w_byte = pipe_data[31:24];
            default: w_byte = pipe_data[7:0];
        endcase
        w_half    = pipe_addr_lo[1] ? pipe_data[31:16] : pipe_data[15:0];
        w_pipe_wd = pipe_data;
        if (pipe_is_load) begin
            case (pipe_ld_type)
                3'b000:  w_pipe_wd = {{24{w_byte[7]}}, w_byte};
                3'b001:  w_pipe_wd = {{16{w_half[15]}}, w_half};
                3'b100:  w_pipe_wd = {24'd0, w_byte};
                3'b101:  w_pipe_wd = {16'd0, w_half};
                default: w_pipe_wd = pipe_data;
            endcase
        end
    end

    always_comb begin
        rf_we_d  = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        busy_d   = busy_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(w_push) - CW'(w_pop);
        if (w_pipe_win) begin
            rf_we_d = 1'b1;
            rf_wa_d = pipe_rd;
            rf_wd_d = w_pipe_wd;
        end else if (!w_empty) begin
            rf_we_d  = 1'b1;
            rf_wa_d  = fifo_rd_q[rd_ptr_q];
            rf_wd_d  = fifo_data_q[rd_ptr_q];
            busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        // Set is applied after clear so a same-cycle issue keeps the bit.
        if (lu_issue && (lu_issue_rd != 5'd0))
            busy_d[lu_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q  <= 1'b0;
            rf_wa_q  <= 5'd0;
            rf_wd_q  <= 32'd0;
            busy_q   <= 32'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_rd_q[wr_ptr_q]   <= lu_done_rd;
            fifo_data_q[wr_ptr_q] <= lu_done_data;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;
    assign busy  = busy_q;

`ifdef WB_BLOCK_CNT_EN
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (w_pipe_win && !w_empty && (blk_cnt_q != {CNT_W{1'b1}}))
            blk_cnt_d = blk_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blk_cnt_q <= '0;
        else
            blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`else
    assign blk_cnt = '0;
`endif

endmodule
`default_nettype wire
